// File: rtl/exmem_pipe_stage.sv
// EX/MEM pipeline stage: carries WB/M/forward control, ALU address, store data
// and destination register through a 2-entry skid buffer with valid/ready.
// State updates on the falling clock edge; reset is asynchronous active-low.
// Optional macro EXMEM_PARITY_EN adds a per-entry even-parity bit (par_out).
module exmem_pipe_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned REG_W  = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              WB_in,
    input  logic              M_in,
    input  logic              fwd_in,
    input  logic [31:0]       addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [REG_W-1:0]  rw_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              WB_out,
    output logic              M_out,
    output logic              fwd_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic [REG_W-1:0]  rw_out,
`ifdef EXMEM_PARITY_EN
    output logic              par_out,
`endif
    output logic [1:0]        occupancy
);

    localparam int unsigned ST_W    = 2;
    localparam int unsigned ALU_W   = 32;

    localparam logic [ST_W-1:0] EMPTY = 2'd0;
    localparam logic [ST_W-1:0] ONE   = 2'd1;
    localparam logic [ST_W-1:0] TWO   = 2'd2;

    typedef struct packed {
        logic              wb;
        logic              m;
        logic              fwd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [REG_W-1:0]  rw;
`ifdef EXMEM_PARITY_EN
        logic              par;
`endif
    } entry_t;

    logic [ST_W-1:0] state_q, state_d;
    entry_t          h_q, h_d;
    entry_t          s_q, s_d;
    entry_t          cap_c;
    logic            accept_c;
    logic            pop_c;
    logic            in_ready_q;
    logic            out_valid_q;

    // Upper ALU result bits are intentionally discarded.
    logic addr_unused;
    assign addr_unused = ^addr_in[ALU_W-1:ADDR_W];

    // Format an incoming entry; writes to R0 never request writeback.
    always_comb begin
        cap_c      = '0;
        cap_c.wb   = WB_in & (rw_in != '0);
        cap_c.m    = M_in;
        cap_c.fwd  = fwd_in;
        cap_c.addr = addr_in[ADDR_W-1:0];
        cap_c.data = data_in;
        cap_c.rw   = rw_in;
`ifdef EXMEM_PARITY_EN
        cap_c.par  = ^data_in;
`endif
    end

    assign accept_c = in_valid & in_ready_q;
    assign pop_c    = out_valid_q & out_ready;

    // Next-state and next-storage selection; flush wins over accept/pop.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        s_d     = s_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_c) begin
                        h_d     = cap_c;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept_c && pop_c) begin
                        h_d     = cap_c;
                    end else if (accept_c) begin
                        s_d     = cap_c;
                        state_d = TWO;
                    end else if (pop_c) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop_c) begin
                        h_d     = s_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State, storage and registered handshake flags.
    always_ff @(negedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= EMPTY;
            h_q         <= '0;
            s_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            s_q         <= s_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign occupancy = 2'(state_q);
    assign WB_out    = h_q.wb;
    assign M_out     = h_q.m;
    assign fwd_out   = h_q.fwd;
    assign addr_out  = h_q.addr;
    assign data_out  = h_q.data;
    assign rw_out    = h_q.rw;
`ifdef EXMEM_PARITY_EN
    assign par_out   = h_q.par;
`endif

endmodule

// File: tb/tb_exmem_pipe_stage.sv
// Directed bench for exmem_pipe_stage; inputs change on posedge, DUT updates
// on negedge, outputs are checked on the following posedge.
module tb_exmem_pipe_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned REG_W  = 5;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              WB_in, M_in, fwd_in;
    logic [31:0]       addr_in;
    logic [DATA_W-1:0] data_in;
    logic [REG_W-1:0]  rw_in;
    logic              out_valid;
    logic              out_ready;
    logic              WB_out, M_out, fwd_out;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_out;
    logic [REG_W-1:0]  rw_out;
    logic [1:0]        occupancy;
`ifdef EXMEM_PARITY_EN
    logic              par_out;
`endif

    int total = 0;
    int bad   = 0;

    exmem_pipe_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .WB_in     (WB_in),
        .M_in      (M_in),
        .fwd_in    (fwd_in),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .rw_in     (rw_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .WB_out    (WB_out),
        .M_out     (M_out),
        .fwd_out   (fwd_out),
        .addr_out  (addr_out),
        .data_out  (data_out),
        .rw_out    (rw_out),
`ifdef EXMEM_PARITY_EN
        .par_out   (par_out),
`endif
        .occupancy (occupancy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic offer(input logic v, input logic wb, input logic m, input logic fwd,
                         input logic [31:0] addr, input logic [DATA_W-1:0] data,
                         input logic [REG_W-1:0] rw);
        in_valid = v;
        WB_in    = wb;
        M_in     = m;
        fwd_in   = fwd;
        addr_in  = addr;
        data_in  = data;
        rw_in    = rw;
    endtask

    // One DUT update: falling edge, then settle to the next rising edge.
    task automatic cyc();
        @(negedge CLK);
        @(posedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0; flush = 1'b0; out_ready = 1'b0;
        offer(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, '0, '0);
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_occ",       64'(occupancy), 64'd0);
        check("rst_data",      64'(data_out),  64'd0);
        check("rst_addr_rw",   64'({addr_out, rw_out, WB_out, M_out, fwd_out}), 64'd0);
        @(posedge CLK);
        RST_N = 1'b1;
        cyc();
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("idle_in_ready",  64'(in_ready),  64'd1);

        // Address truncation and field capture.
        out_ready = 1'b1;
        offer(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFC7, 32'hDEAD_BEEF, 5'd5);
        cyc();
        check("p1_valid", 64'(out_valid), 64'd1);
        check("p1_addr",  64'(addr_out),  64'h07);
        check("p1_data",  64'(data_out),  64'hDEAD_BEEF);
        check("p1_rw",    64'(rw_out),    64'd5);
        check("p1_wb",    64'(WB_out),    64'd1);
        check("p1_fwd",   64'(fwd_out),   64'd1);
        check("p1_occ",   64'(occupancy), 64'd1);
        offer(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, '0, '0);
        cyc();
        check("p1_drain_valid", 64'(out_valid), 64'd0);
        check("p1_hold_data",   64'(data_out),  64'hDEAD_BEEF);

        // R0 destination suppresses writeback.
        offer(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h55, 5'd0);
        cyc();
        check("r0_wb",   64'(WB_out),   64'd0);
        check("r0_rw",   64'(rw_out),   64'd0);
        check("r0_m",    64'(M_out),    64'd1);
        check("r0_addr", 64'(addr_out), 64'h00);
        offer(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, '0, '0);
        cyc();

        // Backpressure: fill both entries, C refused, then drain in order.
        out_ready = 1'b0;
        offer(1'b1, 1'b1, 1'b0, 1'b0, 32'h4, 32'h11, 5'd1);
        cyc();
        check("bp_a_occ", 64'(occupancy), 64'd1);
        offer(1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 32'h22, 5'd2);
        cyc();
        check("bp_b_occ",   64'(occupancy), 64'd2);
        check("bp_b_ready", 64'(in_ready),  64'd0);
        offer(1'b1, 1'b1, 1'b0, 1'b0, 32'hC, 32'h33, 5'd3);
        cyc();
        check("bp_c_occ",  64'(occupancy), 64'd2);
        check("bp_c_head", 64'(data_out),  64'h11);
        out_ready = 1'b1;
        offer(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, '0, '0);
        cyc();
        check("bp_pop_b",     64'(data_out),  64'h22);
        check("bp_pop_b_rw",  64'(rw_out),    64'd2);
        check("bp_pop_occ",   64'(occupancy), 64'd1);
        check("bp_pop_ready", 64'(in_ready),  64'd1);
        offer(1'b1, 1'b1, 1'b0, 1'b0, 32'hC, 32'h33, 5'd3);
        cyc();
        check("bp_c_data", 64'(data_out),  64'h33);
        check("bp_c_addr", 64'(addr_out),  64'h0C);
        check("bp_c_occ1", 64'(occupancy), 64'd1);
        offer(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, '0, '0);
        cyc();
        check("bp_empty", 64'(out_valid), 64'd0);

        // Flush with a simultaneous offer drops everything.
        out_ready = 1'b0;
        offer(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h44, 5'd4);
        cyc();
        offer(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h55, 5'd5);
        cyc();
        check("fl_pre_occ", 64'(occupancy), 64'd2);
        flush = 1'b1;
        offer(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h66, 5'd6);
        cyc();
        check("fl_occ",   64'(occupancy), 64'd0);
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready),  64'd1);
        flush = 1'b0; out_ready = 1'b1;
        offer(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, '0, '0);
        cyc();
        check("fl_no_d_valid", 64'(out_valid), 64'd0);
        check("fl_no_d_data",  64'(data_out),  64'h44);

        // Asynchronous reset with two entries held.
        out_ready = 1'b0;
        offer(1'b1, 1'b1, 1'b1, 1'b1, 32'h3F, 32'h77, 5'd7);
        cyc();
        offer(1'b1, 1'b1, 1'b1, 1'b1, 32'h3E, 32'h88, 5'd8);
        cyc();
        check("ar_pre_occ", 64'(occupancy), 64'd2);
        #2 RST_N = 1'b0;
        #1;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_occ",   64'(occupancy), 64'd0);
        check("ar_ready", 64'(in_ready),  64'd1);
        check("ar_data",  64'(data_out),  64'd0);
        offer(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, '0, '0);
        @(posedge CLK);
        RST_N = 1'b1;
        cyc();

`ifdef EXMEM_PARITY_EN
        out_ready = 1'b1;
        offer(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0007, 5'd1);
        cyc();
        check("par_7", 64'(par_out), 64'd1);
        offer(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0003, 5'd1);
        cyc();
        check("par_3", 64'(par_out), 64'd0);
        offer(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, '0, '0);
        cyc();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
